servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Multi-channel servo PWM generator: one shared period counter drives `CHANNELS` independent servo outputs, each with a position command, clamping, and per-period slew-rate limiting. Commands arrive over a valid/ready port and are applied only at period boundaries, so no output ever produces a runt or stretched pulse. It sits between the arm-control logic and the servo pins, replacing the single-channel PWM generator.

## Interface
- `CHANNELS`, 4: number of servo outputs (≥1).
- `PERIOD_CYCLES`, 1_000_000: clock cycles per PWM period.
- `MIN_PULSE`, 75_000: high cycles at position 0.
- `MAX_PULSE`, 130_000: high cycles at position `POS_MAX`. Requires `MIN_PULSE < MAX_PULSE < PERIOD_CYCLES`.
- `POS_W`, 8: position command width.
- `POS_MAX`, 100: full-scale position (≥1, < 2^POS_W).
- `STEP_MAX`, 2: maximum change of applied position per period; 0 = unlimited (jump directly to target).
- `CNT_W`, 20: counter / pulse width; must hold `PERIOD_CYCLES-1`.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in CHANNELS: per-channel output enable.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_ch` in max(1,$clog2(CHANNELS)): target channel; values ≥ CHANNELS are accepted and discarded.
- `cmd_pos` in POS_W: target position; values > POS_MAX are clamped to POS_MAX.
- `pwm_out` out CHANNELS: servo pulse outputs.
- `frame_start` out 1: one-cycle pulse marking the first cycle of each period.

## Operation
- Counter `cnt` runs 0 … PERIOD_CYCLES-1, then wraps to 0; free-running out of reset.
- Per channel: `target[i]` (command register), `cur[i]` (applied position), `pulse[i]` (high time for current period), `act[i]` (active flag).
- Command accept: `target[cmd_ch] <= min(cmd_pos, POS_MAX)`. Several commands to one channel within a period: last one wins.
- Update cycle (`cnt == PERIOD_CYCLES-1`), for every channel simultaneously:
  - if STEP_MAX==0 or |target−cur| ≤ STEP_MAX: `cur <= target`; else `cur` moves STEP_MAX toward `target`.
  - `pulse <= MIN_PULSE + ((MAX_PULSE−MIN_PULSE) * cur_next) / POS_MAX`, floor division, product width CNT_W+POS_W, no overflow.
  - `act[i] <= en[i]`.
- `pwm_out[i]` (registered) `<= act[i] & en[i] & (cnt < pulse[i])`.
- Enable deassert: output forced 0 the next cycle. Enable assert: output begins only at the next period start (no partial pulse). `cur`/`pulse` keep ramping while disabled.
- `cmd_ready` = 0 only in the update cycle; 1 otherwise (out of reset included).

## Timing
- Reset (`rst_n` low, async): `cnt=0`, `target=cur=POS_MAX/2`, `pulse` = formula at POS_MAX/2, `act=0`, `pwm_out=0`, `frame_start=0`, `cmd_ready=1` after release.
- `frame_start` is high exactly in cycles where `pwm_out` reflects `cnt==0`, i.e. one cycle after `cnt==0`; all `pwm_out` rising edges coincide with it.
- Each active period: `pwm_out[i]` high for exactly `pulse[i]` consecutive cycles starting at `frame_start`, low for the remainder.
- Command latency: command accepted in period k affects `cur` at the boundary ending period k, visible in pulses of period k+1.
- Reset asserted mid-period: outputs drop to 0 immediately (async); first post-reset period produces no pulses (act=0) and begins `frame_start` one cycle after `cnt==0`.
- Wrap-around: no idle cycle between periods; period length is exactly PERIOD_CYCLES.

## Test plan
Use PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=20, POS_MAX=10, STEP_MAX=2, CHANNELS=4, CNT_W=8, POS_W=4.
- Reset release, `en=4'hF`, no commands → period 1 all outputs 0; period 2 on, each output high exactly 15 cycles aligned to `frame_start`, period 100.
- Command ch1 pos 10 from 5 → pulses 15,17,19,20,20 in successive periods (slew 2/period, final step 1); other channels stay 15.
- `cmd_pos=15` on ch2 → clamped to 10; STEP_MAX=0 rebuild: next period pulse 20 directly.
- `cmd_valid` held across update cycle → `cmd_ready` low exactly that cycle, command accepted next cycle, applied one period later; `cmd_ch=5` discarded.
- Drop `en[0]` mid-pulse → `pwm_out[0]` 0 next cycle; reassert mid-period → no pulse until next `frame_start`, then full-width pulse.
- Assert `rst_n` low mid-pulse → all `pwm_out` 0 without clock edge; state returns to reset values.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator with a shared period counter.
// Each channel has a clamped position command, per-period slew limiting and
// an enable that only takes effect at period boundaries when asserted.
module servo_pwm_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned PERIOD_CYCLES = 1_000_000,
  parameter int unsigned MIN_PULSE     = 75_000,
  parameter int unsigned MAX_PULSE     = 130_000,
  parameter int unsigned POS_W         = 8,
  parameter int unsigned POS_MAX       = 100,
  parameter int unsigned STEP_MAX      = 2,
  parameter int unsigned CNT_W         = 20,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [POS_W-1:0]    cmd_pos,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start
);

  localparam int unsigned      PROD_W     = CNT_W + POS_W;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(PERIOD_CYCLES - 2);
  localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_MID    = POS_W'(POS_MAX / 2);
  localparam logic [PROD_W-1:0] SPAN      = PROD_W'(MAX_PULSE - MIN_PULSE);
  localparam logic [PROD_W-1:0] DIV       = PROD_W'(POS_MAX);
  localparam logic [CNT_W-1:0] MIN_V      = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] PULSE_MID  =
    CNT_W'(MIN_PULSE + ((MAX_PULSE - MIN_PULSE) * (POS_MAX / 2)) / POS_MAX);
  // A step at least as large as the full range can never limit anything.
  localparam bit               STEP_UNLIM = (STEP_MAX == 0) || (STEP_MAX >= POS_MAX);
  localparam logic [POS_W-1:0] STEP_V     = POS_W'(STEP_MAX);

  logic [CNT_W-1:0]    r_cnt;
  logic                r_frame;
  logic                r_ready;
  logic [POS_W-1:0]    r_target [CHANNELS];
  logic [POS_W-1:0]    r_cur    [CHANNELS];
  logic [CNT_W-1:0]    r_pulse  [CHANNELS];
  logic [CHANNELS-1:0] r_act;
  logic [CHANNELS-1:0] r_pwm;

  logic                w_update;
  logic                w_accept;
  logic [POS_W-1:0]    w_pos_clamped;
  logic [POS_W-1:0]    w_cur_next   [CHANNELS];
  logic [CNT_W-1:0]    w_pulse_next [CHANNELS];

  // High time for a given applied position; floor division, no overflow.
  function automatic logic [CNT_W-1:0] pulse_of(input logic [POS_W-1:0] pos);
    logic [PROD_W-1:0] prod;
    prod = SPAN * PROD_W'(pos);
    return MIN_V + CNT_W'(prod / DIV);
  endfunction

  assign w_update      = (r_cnt == CNT_LAST);
  assign w_accept      = cmd_valid & r_ready;
  assign w_pos_clamped = (cmd_pos > POS_MAX_V) ? POS_MAX_V : cmd_pos;

  assign cmd_ready   = r_ready;
  assign pwm_out     = r_pwm;
  assign frame_start = r_frame;

  // Next applied position (slew-limited toward target) and its pulse width.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_cur_next[i] = r_target[i];
      if (!STEP_UNLIM) begin
        if ((r_target[i] > r_cur[i]) && ((r_target[i] - r_cur[i]) > STEP_V)) begin
          w_cur_next[i] = r_cur[i] + STEP_V;
        end else if ((r_cur[i] > r_target[i]) && ((r_cur[i] - r_target[i]) > STEP_V)) begin
          w_cur_next[i] = r_cur[i] - STEP_V;
        end
      end
      w_pulse_next[i] = pulse_of(w_cur_next[i]);
    end
  end

  // Period counter, frame marker and command-ready (low only in update cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_frame <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_cnt   <= w_update ? '0 : r_cnt + CNT_W'(1);
      r_frame <= (r_cnt == '0);
      r_ready <= (r_cnt != CNT_PRE);
    end
  end

  // Command capture; out-of-range channels match nothing and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_target[i] <= POS_MID;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (w_accept && (cmd_ch == CH_W'(i))) begin
          r_target[i] <= w_pos_clamped;
        end
      end
    end
  end

  // Applied position and pulse width change only at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_cur[i]   <= POS_MID;
        r_pulse[i] <= PULSE_MID;
      end
    end else if (w_update) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_cur[i]   <= w_cur_next[i];
        r_pulse[i] <= w_pulse_next[i];
      end
    end
  end

  // Active flag arms at the boundary, clears as soon as enable drops, so a
  // re-enable mid-period waits for the next full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= '0;
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_act[i] <= en[i] & (w_update | r_act[i]);
        r_pwm[i] <= r_act[i] & en[i] & (r_cnt < r_pulse[i]);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: a slew-limited 4-channel instance and an
// unlimited-step 5-channel instance share the clock, reset and command stream.
module tb_servo_pwm_multi;

  localparam int PER = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic       cmd_valid;
  logic [1:0] cmd_ch;
  logic [3:0] cmd_pos;
  logic       cmd_ready;
  logic [3:0] pwm_out;
  logic       frame_start;

  logic [4:0] en0;
  logic       cmd_valid0;
  logic [2:0] cmd_ch0;
  logic       cmd_ready0;
  logic [4:0] pwm_out0;
  logic       frame_start0;

  int errors = 0;
  int checks = 0;
  int hi  [4];
  int hi0 [5];
  bit shape_ok;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CHANNELS(4), .PERIOD_CYCLES(100), .MIN_PULSE(10), .MAX_PULSE(20),
    .POS_W(4), .POS_MAX(10), .STEP_MAX(2), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_pos(cmd_pos),
    .pwm_out(pwm_out), .frame_start(frame_start)
  );

  servo_pwm_multi #(
    .CHANNELS(5), .PERIOD_CYCLES(100), .MIN_PULSE(10), .MAX_PULSE(20),
    .POS_W(4), .POS_MAX(10), .STEP_MAX(0), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .cmd_valid(cmd_valid0),
    .cmd_ready(cmd_ready0), .cmd_ch(cmd_ch0), .cmd_pos(cmd_pos),
    .pwm_out(pwm_out0), .frame_start(frame_start0)
  );

  // Channels >= 4 only reach the 5-channel instance.
  task automatic drive_cmd(input bit v, input int ch, input int pos);
    cmd_valid  = v && (ch < 4);
    cmd_valid0 = v;
    cmd_ch     = 2'(ch);
    cmd_ch0    = 3'(ch);
    cmd_pos    = 4'(pos);
  endtask

  // Observe one full period from a frame_start; optionally issue a command
  // in its first cycle. Fills hi/hi0 and shape_ok.
  task automatic measure(input bit cv, input int cch, input int cpos);
    int n;
    bit [3:0] low_seen;
    bit [4:0] low_seen0;
    n = 0;
    shape_ok = 1'b1;
    low_seen = '0;
    low_seen0 = '0;
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int i = 0; i < 5; i++) hi0[i] = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) shape_ok = 1'b0;
    if (cv) drive_cmd(1'b1, cch, cpos);
    for (int k = 0; k < PER; k++) begin
      if (k > 0 && frame_start !== 1'b0) shape_ok = 1'b0;
      if (frame_start0 !== frame_start) shape_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (pwm_out[i] === 1'b1) begin
          if (low_seen[i]) shape_ok = 1'b0;
          hi[i]++;
        end else begin
          low_seen[i] = 1'b1;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (pwm_out0[i] === 1'b1) begin
          if (low_seen0[i]) shape_ok = 1'b0;
          hi0[i]++;
        end else begin
          low_seen0[i] = 1'b1;
        end
      end
      @(negedge clk);
      if (k == 0 && cv) drive_cmd(1'b0, cch, cpos);
    end
    if (frame_start !== 1'b1) shape_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 4'hF;
    en0   = 5'h1F;
    drive_cmd(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 4'h0 || pwm_out0 !== 5'h0) begin
      errors++;
      $display("FAIL reset_pwm: got %h/%h expected 0/0", pwm_out, pwm_out0);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame: got %b expected 0", frame_start);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame: got %b expected 1", frame_start);
    end
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, 0, 0);
      checks++;
      if (!shape_ok) begin
        errors++;
        $display("FAIL reset_shape p%0d: got bad expected aligned pulse/period 100", p);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hi[i] !== ((p == 0) ? 0 : 15)) begin
          errors++;
          $display("FAIL reset_width p%0d ch%0d: got %0d expected %0d", p, i, hi[i], (p == 0) ? 0 : 15);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (hi0[i] !== ((p == 0) ? 0 : 15)) begin
          errors++;
          $display("FAIL reset_width0 p%0d ch%0d: got %0d expected %0d", p, i, hi0[i], (p == 0) ? 0 : 15);
        end
      end
    end
  endtask

  task automatic test_slew();
    int tab  [5] = '{15, 17, 19, 20, 20};
    int tab0 [5] = '{15, 20, 20, 20, 20};
    int e;
    for (int p = 0; p < 5; p++) begin
      measure(p == 0, 1, 10);
      checks++;
      if (!shape_ok) begin
        errors++;
        $display("FAIL slew_shape p%0d: got bad expected aligned pulse/period 100", p);
      end
      for (int i = 0; i < 4; i++) begin
        e = (i == 1) ? tab[p] : 15;
        checks++;
        if (hi[i] !== e) begin
          errors++;
          $display("FAIL slew_width p%0d ch%0d: got %0d expected %0d", p, i, hi[i], e);
        end
      end
      for (int i = 0; i < 5; i++) begin
        e = (i == 1) ? tab0[p] : 15;
        checks++;
        if (hi0[i] !== e) begin
          errors++;
          $display("FAIL jump_width p%0d ch%0d: got %0d expected %0d", p, i, hi0[i], e);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int tab  [4] = '{15, 17, 19, 20};
    int tab0 [4] = '{15, 20, 20, 20};
    int e;
    for (int p = 0; p < 4; p++) begin
      measure(p == 0, 2, 15);
      for (int i = 0; i < 4; i++) begin
        e = (i == 1) ? 20 : ((i == 2) ? tab[p] : 15);
        checks++;
        if (hi[i] !== e) begin
          errors++;
          $display("FAIL clamp_width p%0d ch%0d: got %0d expected %0d", p, i, hi[i], e);
        end
      end
      for (int i = 0; i < 5; i++) begin
        e = (i == 1) ? 20 : ((i == 2) ? tab0[p] : 15);
        checks++;
        if (hi0[i] !== e) begin
          errors++;
          $display("FAIL clamp_width0 p%0d ch%0d: got %0d expected %0d", p, i, hi0[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0a [5] = '{15, 20, 20, 15, 15};
    int e0b [5] = '{15, 20, 20, 10, 15};
    int ea  [4] = '{15, 20, 20, 15};
    int eb  [4] = '{15, 20, 20, 13};
    checks++;
    if (frame_start !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: got frame=%b ready=%b expected 1/1", frame_start, cmd_ready);
    end
    repeat (98) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || cmd_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_low: got %b/%b expected 0/0", cmd_ready, cmd_ready0);
    end
    drive_cmd(1'b1, 3, 0);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_high: got %b/%b expected 1/1", cmd_ready, cmd_ready0);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame: got %b expected 1", frame_start);
    end
    for (int p = 0; p < 2; p++) begin
      measure(p == 0, 5, 0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hi[i] !== ((p == 0) ? ea[i] : eb[i])) begin
          errors++;
          $display("FAIL b2b_width p%0d ch%0d: got %0d expected %0d", p, i, hi[i], (p == 0) ? ea[i] : eb[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (hi0[i] !== ((p == 0) ? e0a[i] : e0b[i])) begin
          errors++;
          $display("FAIL b2b_width0 p%0d ch%0d: got %0d expected %0d", p, i, hi0[i], (p == 0) ? e0a[i] : e0b[i]);
        end
      end
    end
  endtask

  task automatic test_enable();
    int n;
    int cnt_hi;
    int e [4] = '{15, 20, 20, 10};
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_before: got %b expected 1", pwm_out[0]);
    end
    en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b0 || pwm_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL en_drop: got ch0=%b ch1=%b expected 0/1", pwm_out[0], pwm_out[1]);
    end
    en[0] = 1'b1;
    cnt_hi = 0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (frame_start === 1'b1) break;
      if (pwm_out[0] === 1'b1) cnt_hi++;
    end
    checks++;
    if (cnt_hi !== 0 || n >= 300) begin
      errors++;
      $display("FAIL en_partial: got %0d high cycles (wait %0d) expected 0", cnt_hi, n);
    end
    measure(1'b0, 0, 0);
    checks++;
    if (!shape_ok) begin
      errors++;
      $display("FAIL en_shape: got bad expected aligned pulse/period 100");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== e[i]) begin
        errors++;
        $display("FAIL en_width ch%0d: got %0d expected %0d", i, hi[i], e[i]);
      end
    end
    checks++;
    if (hi0[3] !== 10) begin
      errors++;
      $display("FAIL en_width0 ch3: got %0d expected 10", hi0[3]);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 4'hF || pwm_out0 !== 5'h1F) begin
      errors++;
      $display("FAIL rmid_before: got %h/%h expected f/1f", pwm_out, pwm_out0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 4'h0 || pwm_out0 !== 5'h0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async: got pwm=%h/%h ready=%b expected 0/0/1", pwm_out, pwm_out0, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL rmid_frame: got %b expected 1", frame_start);
    end
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hi[i] !== ((p == 0) ? 0 : 15)) begin
          errors++;
          $display("FAIL rmid_width p%0d ch%0d: got %0d expected %0d", p, i, hi[i], (p == 0) ? 0 : 15);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (hi0[i] !== ((p == 0) ? 0 : 15)) begin
          errors++;
          $display("FAIL rmid_width0 p%0d ch%0d: got %0d expected %0d", p, i, hi0[i], (p == 0) ? 0 : 15);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_clamp();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
